// File: rtl/bf16_mult_core.sv
// bf16_mult_core: iterative bfloat16 significand multiplier.
// A shift-add loop retires one multiplier bit per cycle, then a single
// normalization cycle produces the unclamped exponent, the fraction-plus-guard
// field and the sign. Overflow/underflow clamping and packing happen downstream.
module bf16_mult_core #(
  parameter int FRAC_W  = 7,
  parameter int EXP_W   = 8,
  parameter int BIAS    = 127,
  parameter int GUARD_W = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [EXP_W+FRAC_W:0]       a,
  input  logic [EXP_W+FRAC_W:0]       b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [EXP_W+1:0]            expt_pd,
  output logic [FRAC_W+GUARD_W-1:0]   mantissa_pd,
  output logic                        Spd
);

  localparam int SIG_W  = FRAC_W + 1;          // significand incl. hidden bit
  localparam int P_W    = 2 * SIG_W;           // full product width
  localparam int MANT_W = FRAC_W + GUARD_W;    // mantissa_pd width
  localparam int E_W    = EXP_W + 2;           // signed exponent width
  localparam int CNT_W  = $clog2(SIG_W) + 1;   // counts 0..SIG_W inclusive
  localparam int OP_W   = 1 + EXP_W + FRAC_W;

  localparam logic signed [E_W-1:0] BIAS_S = E_W'(BIAS);
  localparam logic [E_W-1:0]        EXP_ZERO = '1;                 // -1
  localparam logic [E_W-1:0]        EXP_INF  = E_W'(1) << EXP_W;   // 2^EXP_W

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t              r_state;
  logic [EXP_W-1:0]    r_exp_a, r_exp_b;
  logic [SIG_W-1:0]    r_sig_a, r_sig_b;
  logic                r_sign;
  logic [P_W-1:0]      r_acc;
  logic [CNT_W-1:0]    r_count;
  logic [E_W-1:0]      r_expt;
  logic [MANT_W-1:0]   r_mant;
  logic                r_spd;
  logic                r_out_valid;

  logic [P_W-1:0]          w_addend;
  logic                    w_bit;
  logic                    w_zero, w_inf;
  logic signed [E_W-1:0]   w_exp_base;
  logic [MANT_W-1:0]       w_mant_hi, w_mant_lo;

  // Partial product for the current multiplier bit and normalization candidates.
  assign w_addend   = {{SIG_W{1'b0}}, r_sig_a} << r_count[CNT_W-2:0];
  assign w_bit      = r_sig_b[r_count[CNT_W-2:0]];
  assign w_zero     = (r_exp_a == '0) || (r_exp_b == '0);
  assign w_inf      = (&r_exp_a) || (&r_exp_b);
  assign w_exp_base = $signed({{(E_W-EXP_W){1'b0}}, r_exp_a})
                    + $signed({{(E_W-EXP_W){1'b0}}, r_exp_b}) - BIAS_S;
  // Product in [1,4): a set top bit means the leading one is one place higher.
  assign w_mant_hi  = {r_acc[P_W-2:0], {(MANT_W-P_W+1){1'b0}}};
  assign w_mant_lo  = {r_acc[P_W-3:0], {(MANT_W-P_W+2){1'b0}}};

  // Control FSM, shift-add datapath and registered result outputs.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would leak new values mid-block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_exp_a     <= '0;
      r_exp_b     <= '0;
      r_sig_a     <= '0;
      r_sig_b     <= '0;
      r_sign      <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
      r_expt      <= '0;
      r_mant      <= '0;
      r_spd       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_exp_a <= a[OP_W-2 -: EXP_W];
            r_exp_b <= b[OP_W-2 -: EXP_W];
            r_sig_a <= {1'b1, a[FRAC_W-1:0]};
            r_sig_b <= {1'b1, b[FRAC_W-1:0]};
            r_sign  <= a[OP_W-1] ^ b[OP_W-1];
            r_acc   <= '0;
            r_count <= '0;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          // One multiplier bit per cycle; the extra terminal cycle (count ==
          // SIG_W) lets the last partial product land before NORM reads acc.
          if (r_count != CNT_W'(SIG_W)) begin
            if (w_bit) r_acc <= r_acc + w_addend;
            r_count <= r_count + 1'b1;
          end else begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_spd <= r_sign;
          if (w_zero) begin
            r_expt <= EXP_ZERO;
            r_mant <= '0;
          end else if (w_inf) begin
            r_expt <= EXP_INF;
            r_mant <= '0;
          end else if (r_acc[P_W-1]) begin
            r_expt <= w_exp_base + E_W'(1);
            r_mant <= w_mant_hi;
          end else begin
            r_expt <= w_exp_base;
            r_mant <= w_mant_lo;
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          // Results stay on the outputs after the handshake until the next NORM.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = r_out_valid;
  assign expt_pd     = r_expt;
  assign mantissa_pd = r_mant;
  assign Spd         = r_spd;

endmodule
